// File: rtl/tm1638_responder_if.sv
// Serial link between a TM1638-style host and the responder.
// The host owns strobe, clock and data-in; the responder owns data-out and its enable.
interface tm1638_responder_if;
    logic tm1638_strobe;
    logic tm1638_clk;
    logic tm1638_dio_i;
    logic tm1638_dio_o;
    logic tm1638_dio_oe;

    modport master (
        output tm1638_strobe,
        output tm1638_clk,
        output tm1638_dio_i,
        input  tm1638_dio_o,
        input  tm1638_dio_oe
    );

    modport slave (
        input  tm1638_strobe,
        input  tm1638_clk,
        input  tm1638_dio_i,
        output tm1638_dio_o,
        output tm1638_dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// TM1638-compatible serial responder: decodes host commands, holds a 16-byte display RAM
// and display settings, and shifts a key-scan snapshot back to the host on read frames.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    tm1638_responder_if.slave      bus,
    input  logic [8*KEY_BYTES-1:0] keys,
    input  logic [3:0]             ram_raddr,
    output logic [7:0]             ram_rdata,
    output logic                   display_on,
    output logic [2:0]             brightness,
    output logic                   frame_done
);

    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] stb_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] dio_sync;
    logic                   stb_d;
    logic                   sclk_d;
    logic [6:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   mode_read;
    logic                   mode_fixed;
    logic [3:0]             addr;
    logic [8*KEY_BYTES-1:0] snap;
    logic                   dio_o_r;
    logic                   dio_oe_r;
    logic [7:0]             ram [16];

    logic       stb_s, sclk_s, dio_s;
    logic       stb_fall, stb_rise, sclk_rise, sclk_fall;
    logic [7:0] rx_byte;

    assign stb_s     = stb_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign dio_s     = dio_sync[SYNC_STAGES-1];
    assign stb_fall  = stb_d & ~stb_s;
    assign stb_rise  = ~stb_d & stb_s;
    assign sclk_rise = ~sclk_d & sclk_s;
    assign sclk_fall = sclk_d & ~sclk_s;
    // Bits arrive LSB-first, so the newest bit lands in the MSB.
    assign rx_byte   = {dio_s, shreg};

    assign bus.tm1638_dio_o  = dio_o_r;
    assign bus.tm1638_dio_oe = dio_oe_r;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stb_sync   <= '1;
            sclk_sync  <= '1;
            dio_sync   <= '1;
            stb_d      <= 1'b1;
            sclk_d     <= 1'b1;
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            mode_read  <= 1'b0;
            mode_fixed <= 1'b0;
            addr       <= '0;
            snap       <= '0;
            dio_o_r    <= 1'b0;
            dio_oe_r   <= 1'b0;
            frame_done <= 1'b0;
            display_on <= 1'b0;
            brightness <= '0;
            ram_rdata  <= '0;
            for (int i = 0; i < 16; i++) ram[i] <= '0;
        end else begin
            stb_sync[0]  <= bus.tm1638_strobe;
            sclk_sync[0] <= bus.tm1638_clk;
            dio_sync[0]  <= bus.tm1638_dio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stb_sync[i]  <= stb_sync[i-1];
                sclk_sync[i] <= sclk_sync[i-1];
                dio_sync[i]  <= dio_sync[i-1];
            end
            stb_d      <= stb_s;
            sclk_d     <= sclk_s;
            frame_done <= 1'b0;
            ram_rdata  <= ram[ram_raddr];

            // Strobe release ends the frame from any active state; partial bytes are dropped.
            if (state != IDLE && stb_rise) begin
                state    <= IDLE;
                frame_done <= 1'b1;
                dio_oe_r <= 1'b0;
                dio_o_r  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (stb_fall) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shreg   <= rx_byte[7:1];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (rx_byte[7:6])
                                    2'b01: begin
                                        mode_read  <= rx_byte[1];
                                        mode_fixed <= rx_byte[2];
                                        if (rx_byte[1]) begin
                                            state <= READ;
                                            snap  <= keys;
                                        end else begin
                                            state <= IGNORE;
                                        end
                                    end
                                    2'b10: begin
                                        display_on <= rx_byte[3];
                                        brightness <= rx_byte[2:0];
                                        state      <= IGNORE;
                                    end
                                    2'b11: begin
                                        addr  <= rx_byte[3:0];
                                        state <= mode_read ? IGNORE : WRITE;
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                        end
                    end
                    WRITE: begin
                        if (sclk_rise) begin
                            shreg   <= rx_byte[7:1];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ram[addr] <= rx_byte;
                                if (!mode_fixed) addr <= addr + 4'd1;
                            end
                        end
                    end
                    READ: begin
                        // Snapshot shifts out with zero fill, so trailing bits read as 0.
                        if (sclk_fall) begin
                            dio_oe_r <= 1'b1;
                            dio_o_r  <= snap[0];
                            snap     <= {1'b0, snap[8*KEY_BYTES-1:1]};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: host frames are bit-banged and results compared
// against hand-computed values.
module tb_tm1638_responder;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [31:0] keys;
    logic [3:0]  ram_raddr;
    logic [7:0]  ram_rdata;
    logic        display_on;
    logic [2:0]  brightness;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int fd_count    = 0;
    int fd_base;
    logic [7:0] rd;

    always #5 clk = ~clk;

    tm1638_responder_if bus ();

    tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .bus        (bus),
        .keys       (keys),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .display_on (display_on),
        .brightness (brightness),
        .frame_done (frame_done)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic start_frame();
        bus.tm1638_strobe = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic end_frame();
        bus.tm1638_strobe = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.tm1638_clk   = 1'b0;
            bus.tm1638_dio_i = b[i];
            wait_cyc(HALF);
            bus.tm1638_clk   = 1'b1;
            wait_cyc(HALF);
        end
    endtask

    task automatic read_bits(input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            bus.tm1638_clk = 1'b0;
            wait_cyc(HALF);
            @(negedge clk);
            r[i] = bus.tm1638_dio_o;
            bus.tm1638_clk = 1'b1;
            wait_cyc(HALF);
        end
    endtask

    task automatic one_byte_frame(input logic [7:0] b);
        start_frame();
        send_bits(b, 8);
        end_frame();
    endtask

    task automatic check_ram(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ram_raddr = a;
        wait_cyc(3);
        @(negedge clk);
        check(tag, {24'd0, ram_rdata}, {24'd0, exp});
    endtask

    initial begin
        n_rst             = 1'b0;
        bus.tm1638_strobe = 1'b1;
        bus.tm1638_clk    = 1'b1;
        bus.tm1638_dio_i  = 1'b1;
        keys              = '0;
        ram_raddr         = '0;
        wait_cyc(3);
        n_rst = 1'b1;
        wait_cyc(4);
        @(negedge clk);
        check("rst_dio_oe",     {31'd0, bus.tm1638_dio_oe}, 32'd0);
        check("rst_dio_o",      {31'd0, bus.tm1638_dio_o},  32'd0);
        check("rst_frame_done", {31'd0, frame_done},        32'd0);
        check("rst_display_on", {31'd0, display_on},        32'd0);
        check("rst_brightness", {29'd0, brightness},        32'd0);
        check("rst_ram_rdata",  {24'd0, ram_rdata},         32'd0);

        // Auto-increment write
        fd_base = fd_count;
        one_byte_frame(8'h40);
        start_frame();
        send_bits(8'hC0, 8); send_bits(8'h06, 8); send_bits(8'h5B, 8); send_bits(8'h4F, 8);
        end_frame();
        check_ram("inc_ram0", 4'h0, 8'h06);
        check_ram("inc_ram1", 4'h1, 8'h5B);
        check_ram("inc_ram2", 4'h2, 8'h4F);
        check_ram("inc_ram3", 4'h3, 8'h00);
        check("inc_frame_done", fd_count - fd_base, 32'd2);

        // Fixed address, then wrap from 0xF to 0x0
        one_byte_frame(8'h44);
        start_frame();
        send_bits(8'hCF, 8); send_bits(8'h11, 8); send_bits(8'h22, 8);
        end_frame();
        check_ram("fix_ramF", 4'hF, 8'h22);
        check_ram("fix_ram0", 4'h0, 8'h06);
        one_byte_frame(8'h40);
        start_frame();
        send_bits(8'hCF, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8);
        end_frame();
        check_ram("wrap_ramF", 4'hF, 8'hAA);
        check_ram("wrap_ram0", 4'h0, 8'hBB);

        // Display control
        one_byte_frame(8'h8C);
        check("dc1_on",  {31'd0, display_on}, 32'd1);
        check("dc1_bri", {29'd0, brightness}, 32'd4);
        one_byte_frame(8'h87);
        check("dc2_on",  {31'd0, display_on}, 32'd0);
        check("dc2_bri", {29'd0, brightness}, 32'd7);

        // Key read with keys changed after the snapshot
        keys = 32'h08_04_02_01;
        start_frame();
        send_bits(8'h42, 8);
        read_bits(8, rd);
        check("key_byte0", {24'd0, rd}, 32'h01);
        check("key_oe_hi", {31'd0, bus.tm1638_dio_oe}, 32'd1);
        keys = 32'hA5_5A_C3_3C;
        read_bits(8, rd); check("key_byte1", {24'd0, rd}, 32'h02);
        read_bits(8, rd); check("key_byte2", {24'd0, rd}, 32'h04);
        read_bits(8, rd); check("key_byte3", {24'd0, rd}, 32'h08);
        read_bits(8, rd); check("key_byte4", {24'd0, rd}, 32'h00);
        end_frame();
        check("key_oe_lo", {31'd0, bus.tm1638_dio_oe}, 32'd0);

        // Aborted address byte and partial data bits
        fd_base = fd_count;
        one_byte_frame(8'h40);
        start_frame();
        send_bits(8'hC3, 8);
        send_bits(8'h77, 5);
        end_frame();
        check_ram("abort_ram3", 4'h3, 8'h00);
        check("abort_frame_done", fd_count - fd_base, 32'd2);

        // Reset during bit 12 of a read
        start_frame();
        send_bits(8'h42, 8);
        read_bits(8, rd);
        read_bits(4, rd);
        bus.tm1638_clk = 1'b0;
        wait_cyc(HALF);
        @(negedge clk);
        check("rrst_oe_before", {31'd0, bus.tm1638_dio_oe}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("rrst_oe_now", {31'd0, bus.tm1638_dio_oe}, 32'd0);
        bus.tm1638_clk    = 1'b1;
        bus.tm1638_strobe = 1'b1;
        wait_cyc(4);
        n_rst = 1'b1;
        wait_cyc(4);
        check_ram("rrst_ram_clear", 4'h0, 8'h00);
        one_byte_frame(8'h8F);
        check("rrst_dc_on",  {31'd0, display_on}, 32'd1);
        check("rrst_dc_bri", {29'd0, brightness}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on each of strobe, clk and dio.
REQ-002 The block SHALL have parameter KEY_BYTES, default 4, giving the number of key bytes returned per read frame.
REQ-003 clk  in  1  system clock; the only clock in the block.
REQ-004 n_rst  in  1  asynchronous, active-low reset.
REQ-005 tm1638_strobe  in  1  host strobe; low = frame active.
REQ-006 tm1638_clk  in  1  host serial clock; idle high.
REQ-007 tm1638_dio_i  in  1  serial data from host.
REQ-008 tm1638_dio_o  out  1  serial data to host.
REQ-009 tm1638_dio_oe  out  1  high = responder drives the DIO line.
REQ-010 keys  in  8*KEY_BYTES  key-scan image; byte n = keys[8n+7:8n].
REQ-011 ram_raddr  in  4  display RAM read address.
REQ-012 ram_rdata  out  8  registered display RAM data at ram_raddr.
REQ-013 display_on  out  1  display enable from the display-control command.
REQ-014 brightness  out  3  brightness from the display-control command.
REQ-015 frame_done  out  1  one-cycle pulse when a frame ends.

Function
REQ-016 All three serial inputs SHALL pass through SYNC_STAGES flops; all edges SHALL be detected on the synchronized signals. Correct operation requires clk at least 4x the tm1638_clk frequency.
REQ-017 The FSM SHALL have the states IDLE, CMD, WRITE, READ and IGNORE.
- IDLE -> CMD on a strobe falling edge.
- Any state -> IDLE on a strobe rising edge, which pulses frame_done.
REQ-018 Bits SHALL be sampled LSB-first on tm1638_clk rising edges. A byte completes in the cycle in which the 8th rising edge is detected.
REQ-019 The first byte of a frame SHALL be decoded from bits [7:6]:
- 01: data command. bit1 sets mode_read; bit2 sets mode_fixed. Go to READ if bit1=1, else go to IGNORE.
- 10: display control. Update display_on from bit3 and brightness from bits[2:0] one cycle after byte completion, then go to IGNORE.
- 11: address command. Set addr from bits[3:0]. Go to WRITE if mode_read=0, else go to IGNORE.
- 00: go to IGNORE.
REQ-020 In WRITE, each completed byte SHALL be written to ram[addr] at the next clk edge. If mode_fixed=0, addr then increments by 1, wrapping 0xF -> 0x0.
REQ-021 mode_read, mode_fixed and addr SHALL persist across frames.
REQ-022 On entry to READ, keys SHALL be latched into a snapshot register, so a frame returns one consistent image.
REQ-023 In READ, output behaviour SHALL be as follows:
- tm1638_dio_oe asserts on the tm1638_clk falling edge that ends the command byte.
- At that edge tm1638_dio_o presents snapshot byte 0, bit 0.
- Each later falling edge advances one bit, LSB-first, bytes in ascending order.
- After 8*KEY_BYTES bits, tm1638_dio_o SHALL be 0.
- tm1638_dio_oe stays high until the strobe rises.
REQ-024 tm1638_dio_oe SHALL be 0 in every state except READ.
REQ-025 A strobe rising edge mid-byte SHALL discard the partial byte, with no RAM write and no register update.
REQ-026 In IGNORE, all clock edges SHALL be consumed with no side effects.
REQ-027 When ram_raddr equals a write address in the same cycle as a write, ram_rdata SHALL show the old value that cycle and the new value the following cycle.
REQ-028 Clock edges seen while the strobe is high SHALL be ignored.

Reset
REQ-029 Assertion of n_rst SHALL immediately force the following reset values:
- state = IDLE
- tm1638_dio_oe = 0, tm1638_dio_o = 0, frame_done = 0
- display_on = 0, brightness = 0
- mode_read = 0, mode_fixed = 0, addr = 0
- ram_rdata = 0, synchronizers = idle-high
REQ-030 Display RAM contents SHALL be cleared to 0x00 by reset.
REQ-031 Reset asserted mid-frame SHALL abort the frame. After release, the block SHALL wait for the next strobe falling edge.

Verification
REQ-032 Auto-increment write: frame 0x40; frame 0xC0,0x06,0x5B,0x4F -> ram[0..2]=06,5B,4F; ram[3]=00.
REQ-033 Fixed address and wrap: frame 0x44; frame 0xCF,0x11,0x22 -> ram[F]=22, ram[0] unchanged. Then frame 0x40; frame 0xCF,0xAA,0xBB -> ram[F]=AA, ram[0]=BB.
REQ-034 Key read: keys=0x08_04_02_01, frame 0x42 with 40 clocks -> host samples bytes 01,02,04,08,00. Changing keys mid-frame does not alter the returned bytes. tm1638_dio_oe falls with the strobe.
REQ-035 Display control: frame 0x8C -> display_on=1, brightness=4. Then frame 0x87 -> display_on=0, brightness=7.
REQ-036 Aborted byte: frame 0x40; frame 0xC3 then 5 bits then strobe high -> ram[3] unchanged; frame_done pulses once per frame.
REQ-037 Reset mid-read: n_rst low during bit 12 of a read -> tm1638_dio_oe=0 at once; a following frame 0x8F decodes correctly.
